// File: rtl/lockstep_align_unit.sv
// Lockstep request/response aligner between NUM_CORES core ports and the TCDM interconnect.
// Optional divergence monitor enabled by defining LOCKSTEP_MISMATCH_EN.
module lockstep_align_unit #(
    parameter int NUM_CORES  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             lockstep_en_i,
    input  logic                             broadcast_i,
    input  logic [NUM_CORES-1:0]             req_i,
    output logic [NUM_CORES-1:0]             gnt_o,
    output logic [NUM_CORES-1:0]             rvalid_o,
    output logic [NUM_CORES*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_CORES-1:0]             req_o,
    input  logic [NUM_CORES-1:0]             gnt_i,
    input  logic [NUM_CORES-1:0]             rvalid_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  rdata_i,
    output logic                             busy_o,
    output logic                             mismatch_o,
    output logic [CNT_WIDTH-1:0]             mismatch_cnt_o,
    input  logic                             clr_mismatch_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic [1:0]                         state_q, state_d;
    logic [NUM_CORES-1:0]               grp_mask_q, grp_mask_d;
    logic                               grp_bcast_q, grp_bcast_d;
    logic [NUM_CORES-1:0]               gnt_seen_q, gnt_seen_d;
    logic [NUM_CORES-1:0]               rv_seen_q, rv_seen_d;
    logic [NUM_CORES*DATA_WIDTH-1:0]    buf_q, buf_d;

    logic                               gnt_done;
    logic [NUM_CORES-1:0]               gnt_acc;
    logic [NUM_CORES-1:0]               rv_hit;

    always_comb begin
        state_d     = state_q;
        grp_mask_d  = grp_mask_q;
        grp_bcast_d = grp_bcast_q;
        gnt_seen_d  = gnt_seen_q;
        rv_seen_d   = rv_seen_q;
        buf_d       = buf_q;
        gnt_done    = 1'b0;
        gnt_acc     = '0;
        rv_hit      = '0;
        req_o       = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (!lockstep_en_i) begin
                    req_o    = req_i;
                    gnt_o    = gnt_i;
                    rvalid_o = rvalid_i;
                    rdata_o  = rdata_i;
                end else if (|req_i) begin
                    grp_mask_d  = req_i;
                    grp_bcast_d = broadcast_i;
                    if (broadcast_i) begin
                        req_o[0] = req_i[0];
                        gnt_done = gnt_i[0];
                    end else begin
                        req_o    = req_i;
                        gnt_done = ((gnt_i & req_i) == req_i);
                    end
                    // All grants in the start cycle skip the collect state entirely
                    if (gnt_done) begin
                        gnt_o   = req_i;
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_GNT;
                        if (!broadcast_i) begin
                            gnt_seen_d = gnt_i & req_i;
                        end
                    end
                end
            end

            ST_GNT: begin
                if (grp_bcast_q) begin
                    req_o[0] = req_i[0];
                    gnt_done = gnt_i[0];
                end else begin
                    req_o    = req_i & grp_mask_q & ~gnt_seen_q;
                    gnt_acc  = gnt_seen_q | (gnt_i & grp_mask_q);
                    gnt_done = (gnt_acc == grp_mask_q);
                    gnt_seen_d = gnt_acc;
                end
                if (gnt_done) begin
                    gnt_o      = grp_mask_q;
                    gnt_seen_d = '0;
                    state_d    = ST_RSP;
                end
            end

            ST_RSP: begin
                if (grp_bcast_q) begin
                    if (rvalid_i[0]) begin
                        rvalid_o = grp_mask_q;
                        for (int k = 0; k < NUM_CORES; k++) begin
                            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata_i[DATA_WIDTH-1:0];
                        end
                        state_d = ST_IDLE;
                    end
                end else begin
                    rv_hit = rvalid_i & grp_mask_q;
                    // Data arriving this cycle is bypassed so release adds no latency
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (rv_hit[k]) begin
                            buf_d[k*DATA_WIDTH +: DATA_WIDTH]   = rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if ((rv_seen_q | rv_hit) == grp_mask_q) begin
                        rvalid_o  = grp_mask_q;
                        rv_seen_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        rv_seen_d = rv_seen_q | rv_hit;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            grp_mask_q  <= '0;
            grp_bcast_q <= 1'b0;
            gnt_seen_q  <= '0;
            rv_seen_q   <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            grp_mask_q  <= grp_mask_d;
            grp_bcast_q <= grp_bcast_d;
            gnt_seen_q  <= gnt_seen_d;
            rv_seen_q   <= rv_seen_d;
            buf_q       <= buf_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);

`ifdef LOCKSTEP_MISMATCH_EN
    logic                 mismatch_q;
    logic [CNT_WIDTH-1:0] mismatch_cnt_q;
    logic                 grp_start;

    // A group that does not include every core means the cores have diverged
    assign grp_start = (state_q == ST_IDLE) && lockstep_en_i && (|req_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mismatch_q     <= 1'b0;
            mismatch_cnt_q <= '0;
        end else if (clr_mismatch_i) begin
            mismatch_q     <= 1'b0;
            mismatch_cnt_q <= '0;
        end else if (grp_start && (req_i != '1)) begin
            mismatch_q <= 1'b1;
            if (mismatch_cnt_q != '1) begin
                mismatch_cnt_q <= mismatch_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign mismatch_o     = mismatch_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
`else
    logic unused_clr;

    assign unused_clr     = clr_mismatch_i;
    assign mismatch_o     = 1'b0;
    assign mismatch_cnt_o = '0;
`endif

endmodule
